// File: rtl/pet_stats_engine_if.sv
// Care-command byte channel between the UART receiver (master) and the stats engine (slave).
interface pet_stats_engine_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/pet_stats_engine.sv
// Saturating pet stat channels with tick-driven random decay, awake/sleep/sick FSM and care commands.
// Optional macro STATS_AGE_EN builds the 16-bit tick age counter; otherwise age is tied to 0.
module pet_stats_engine #(
    parameter int N_STATS    = 5,
    parameter int STAT_W     = 5,
    parameter int TICK_DIV   = 10_000_000,
    parameter int BOOST      = 4,
    parameter int ENERGY_IDX = 3,
    parameter int ALARM_LVL  = 8,
    parameter int SICK_COUNT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  rnd,
    pet_stats_engine_if.slave           cmd,
    output logic                        tick,
    output logic [N_STATS*STAT_W-1:0]   stats_flat,
    output logic [N_STATS-1:0]          alarm,
    output logic                        is_sleeping,
    output logic [1:0]                  pet_state,
    output logic [15:0]                 age
);
    typedef enum logic [1:0] {AWAKE = 2'd0, SLEEP = 2'd1, SICK = 2'd2} state_t;

    localparam int                 CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [STAT_W-1:0]  STAT_MAX  = '1;
    localparam logic [STAT_W:0]    BOOST_AMT = (STAT_W+1)'(BOOST);
    localparam logic [STAT_W:0]    ALARM_THR = (STAT_W+1)'(ALARM_LVL);
    localparam logic [3:0]         OP_BOOST  = 4'h1;
    localparam logic [3:0]         OP_SLEEP  = 4'h2;
    localparam logic [3:0]         OP_WAKE   = 4'h3;
    localparam logic [3:0]         OP_REVIVE = 4'hF;

    logic [CNT_W-1:0]  tick_cnt;
    state_t            state_q, state_d;
    logic [STAT_W-1:0] stat_q [N_STATS];
    logic [STAT_W-1:0] stat_d [N_STATS];
    logic              accept;
    logic [3:0]        opcode, idx;
    logic [3:0]        zero_cnt;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] s, input logic [STAT_W:0] amt);
        logic [STAT_W:0] sum;
        sum = {1'b0, s} + amt;
        return (sum > {1'b0, STAT_MAX}) ? STAT_MAX : sum[STAT_W-1:0];
    endfunction

    function automatic logic [STAT_W-1:0] sat_dec(input logic [STAT_W-1:0] s);
        logic [STAT_W:0] diff;
        diff = {1'b0, s} - (STAT_W+1)'(1);
        return diff[STAT_W] ? '0 : diff[STAT_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Commands are refused in the tick cycle so decay and care never update a stat on the same edge.
    assign tick          = (tick_cnt == CNT_LAST);
    assign cmd.cmd_ready = !tick;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign opcode        = cmd.cmd_data[7:4];
    assign idx           = cmd.cmd_data[3:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        for (int i = 0; i < N_STATS; i++) stat_d[i] = stat_q[i];
        if (tick) begin
            for (int i = 0; i < N_STATS; i++) begin
                if (state_q == AWAKE && rnd[3'(i % 8)])
                    stat_d[i] = sat_dec(stat_q[i]);
                else if (state_q == SLEEP && i == ENERGY_IDX)
                    stat_d[i] = sat_add(stat_q[i], (STAT_W+1)'(1));
                else if (state_q == SLEEP && rnd[3'(i % 8)] && rnd[3'((i + 4) % 8)])
                    stat_d[i] = sat_dec(stat_q[i]);
            end
        end else if (accept) begin
            for (int i = 0; i < N_STATS; i++) begin
                if (opcode == OP_BOOST && state_q != SICK && idx == 4'(i))
                    stat_d[i] = sat_add(stat_q[i], BOOST_AMT);
                else if (opcode == OP_REVIVE && state_q == SICK)
                    stat_d[i] = STAT_MAX;
            end
        end
    end

    // Transitions look at the post-update stats, so sickness and auto-wake land on the same edge.
    always_comb begin
        state_d  = state_q;
        zero_cnt = '0;
        for (int i = 0; i < N_STATS; i++)
            if (stat_d[i] == '0) zero_cnt = zero_cnt + 4'd1;
        if (accept) begin
            if (opcode == OP_SLEEP && state_q == AWAKE)       state_d = SLEEP;
            else if (opcode == OP_WAKE && state_q == SLEEP)   state_d = AWAKE;
            else if (opcode == OP_REVIVE && state_q == SICK)  state_d = AWAKE;
        end
        if (state_q == SLEEP && state_d == SLEEP && stat_d[ENERGY_IDX] == STAT_MAX)
            state_d = AWAKE;
        if (zero_cnt >= 4'(SICK_COUNT))
            state_d = SICK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= AWAKE;
        else       state_q <= state_d;
    end

    // NOTE: the stat array is a handful of flops, not a RAM, so it is reset to full health like any register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_STATS; i++) stat_q[i] <= STAT_MAX;
        end else begin
            for (int i = 0; i < N_STATS; i++) stat_q[i] <= stat_d[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm <= '0;
        end else begin
            for (int i = 0; i < N_STATS; i++) alarm[i] <= ({1'b0, stat_q[i]} < ALARM_THR);
        end
    end

    always_comb begin
        stats_flat = '0;
        for (int i = 0; i < N_STATS; i++) stats_flat[i*STAT_W +: STAT_W] = stat_q[i];
    end

    assign is_sleeping = (state_q == SLEEP);
    assign pet_state   = state_q;

`ifdef STATS_AGE_EN
    logic [15:0] age_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            age_q <= '0;
        else if (accept && opcode == OP_REVIVE && state_q == SICK)
            age_q <= '0;
        else if (tick && state_q != SICK && age_q != 16'hFFFF)
            age_q <= age_q + 16'd1;
    end

    assign age = age_q;
`else
    assign age = '0;
`endif
endmodule

// File: tb/tb_pet_stats_engine.sv
// Scoreboard bench for pet_stats_engine (TICK_DIV=4): stimulus queues expected stats/state per update event.
module tb_pet_stats_engine;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rnd = 8'h00;
    logic        tick;
    logic [24:0] stats_flat;
    logic [4:0]  alarm;
    logic        is_sleeping;
    logic [1:0]  pet_state;
    logic [15:0] age;

    pet_stats_engine_if cmd_if();

    pet_stats_engine #(.TICK_DIV(TICK_DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .rnd         (rnd),
        .cmd         (cmd_if.slave),
        .tick        (tick),
        .stats_flat  (stats_flat),
        .alarm       (alarm),
        .is_sleeping (is_sleeping),
        .pet_state   (pet_state),
        .age         (age)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [24:0] flat;
        logic [1:0]  st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input int s0, input int s1, input int s2,
                                input int s3, input int s4, input int st);
        exp_t e;
        e.tag  = tag;
        e.flat = {5'(s4), 5'(s3), 5'(s2), 5'(s1), 5'(s0)};
        e.st   = 2'(st);
        return e;
    endfunction

    // Monitor: an update event is a tick or an accepted command seen at a rising edge.
    logic ev = 1'b0;
    initial forever begin
        @(posedge clk);
        ev = !reset && (tick || (cmd_if.cmd_valid && cmd_if.cmd_ready));
    end

    initial begin
        exp_t       e;
        logic [4:0] pend_alarm;
        logic       pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("alarm_lag", 32'(alarm), 32'(pend_alarm));
                    pend = 1'b0;
                end
                if (ev) begin
                    if (q.size() == 0) begin
                        check("unexpected_event", 32'(1), 32'(0));
                    end else begin
                        e = q.pop_front();
                        check({e.tag, ".stats"}, 32'(stats_flat), 32'(e.flat));
                        check({e.tag, ".state"}, 32'(pet_state), 32'(e.st));
                        check({e.tag, ".sleep"}, 32'(is_sleeping), 32'(e.st == 2'd1));
                        for (int i = 0; i < 5; i++) pend_alarm[i] = (e.flat[i*5 +: 5] < 5'd8);
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    // All tasks start and end at a falling edge.
    task automatic tick_step(input logic [7:0] r, input exp_t e);
        int n = 0;
        rnd = r;
        while (!tick && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!tick) check({e.tag, ".tick_wait"}, 32'(0), 32'(1));
        else       q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] d, input exp_t e);
        int n = 0;
        while (!cmd_if.cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = d;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic tick_period(input string tag);
        for (int c = 0; c < 12; c++) begin
            check($sformatf("%s.tick_c%0d", tag, c), 32'(tick), 32'(c % 4 == 3));
            check($sformatf("%s.ready_c%0d", tag, c), 32'(cmd_if.cmd_ready), 32'(c % 4 != 3));
            if (c % 4 == 3) q.push_back(mk({tag, ".idle_tick"}, 31, 31, 31, 31, 31, 0));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state and tick period
        check("rst.stats", 32'(stats_flat), 32'h1FF_FFFF);
        check("rst.alarm", 32'(alarm), 32'(0));
        check("rst.state", 32'(pet_state), 32'(0));
        check("rst.sleep", 32'(is_sleeping), 32'(0));
        check("rst.age", 32'(age), 32'(0));
        tick_period("per");

        // Random decay and alarm lag
        tick_step(8'h05, mk("d05_1", 30, 31, 30, 31, 31, 0));
        tick_step(8'h05, mk("d05_2", 29, 31, 29, 31, 31, 0));
        tick_step(8'h05, mk("d05_3", 28, 31, 28, 31, 31, 0));
        for (int k = 1; k <= 21; k++)
            tick_step(8'hFF, mk($sformatf("dFF_%0d", k), 28 - k, 31 - k, 28 - k, 31 - k, 31 - k, 0));
        check("alarm0_before_lag", 32'(alarm[0]), 32'(0));
        @(negedge clk);
        check("alarm0_after_lag", 32'(alarm[0]), 32'(1));
        apply_reset();

        // Boost saturation, dropped commands, command held across a tick
        tick_step(8'h04, mk("b_t1", 31, 31, 30, 31, 31, 0));
        tick_step(8'h04, mk("b_t2", 31, 31, 29, 31, 31, 0));
        send_cmd(8'h12, mk("b_sat2", 31, 31, 31, 31, 31, 0));
        send_cmd(8'h17, mk("b_idx7", 31, 31, 31, 31, 31, 0));
        send_cmd(8'h52, mk("b_badop", 31, 31, 31, 31, 31, 0));
        for (int k = 1; k <= 6; k++)
            tick_step(8'hFF, mk($sformatf("b_dec%0d", k), 31 - k, 31 - k, 31 - k, 31 - k, 31 - k, 0));
        send_cmd(8'h14, mk("b_add4", 25, 25, 25, 25, 29, 0));
        rnd = 8'h00;
        n = 0;
        while (!tick && n < 8) begin
            @(negedge clk);
            n++;
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_data  = 8'h11;
        check("hold.ready_in_tick", 32'(cmd_if.cmd_ready), 32'(0));
        q.push_back(mk("hold.tick", 25, 25, 25, 25, 29, 0));
        q.push_back(mk("hold.cmd", 25, 29, 25, 25, 29, 0));
        @(posedge clk);
        @(negedge clk);
        check("hold.ready_after", 32'(cmd_if.cmd_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        apply_reset();

        // Sleep, energy recharge, auto-wake, wake command, revive ignored when healthy
        for (int k = 1; k <= 4; k++)
            tick_step(8'h08, mk($sformatf("s_pre%0d", k), 31, 31, 31, 31 - k, 31, 0));
        send_cmd(8'h20, mk("s_sleep", 31, 31, 31, 27, 31, 1));
        check("s_is_sleeping", 32'(is_sleeping), 32'(1));
        tick_step(8'h0F, mk("s_t1", 31, 31, 31, 28, 31, 1));
        tick_step(8'h0F, mk("s_t2", 31, 31, 31, 29, 31, 1));
        tick_step(8'h0F, mk("s_t3", 31, 31, 31, 30, 31, 1));
        tick_step(8'h0F, mk("s_autowake", 31, 31, 31, 31, 31, 0));
        tick_step(8'h08, mk("s_dec3", 31, 31, 31, 30, 31, 0));
        send_cmd(8'h20, mk("s_sleep2", 31, 31, 31, 30, 31, 1));
        send_cmd(8'h30, mk("s_wake", 31, 31, 31, 30, 31, 0));
        check("s_woken", 32'(is_sleeping), 32'(0));
        send_cmd(8'hF0, mk("s_revive_ign", 31, 31, 31, 30, 31, 0));
        apply_reset();

        // Sickness: one zero is tolerated, the second forces SICK; SICK freezes stats until REVIVE
        for (int k = 1; k <= 28; k++)
            tick_step(8'hFF, mk($sformatf("k_dec%0d", k), 31 - k, 31 - k, 31 - k, 31 - k, 31 - k, 0));
        tick_step(8'h01, mk("k_z1", 2, 3, 3, 3, 3, 0));
        tick_step(8'h01, mk("k_z2", 1, 3, 3, 3, 3, 0));
        tick_step(8'h01, mk("k_onezero", 0, 3, 3, 3, 3, 0));
        tick_step(8'hFF, mk("k_floor", 0, 2, 2, 2, 2, 0));
        tick_step(8'hFF, mk("k_f1", 0, 1, 1, 1, 1, 0));
        tick_step(8'hFF, mk("k_sick", 0, 0, 0, 0, 0, 2));
        tick_step(8'hFF, mk("k_frozen1", 0, 0, 0, 0, 0, 2));
        tick_step(8'hFF, mk("k_frozen2", 0, 0, 0, 0, 0, 2));
        send_cmd(8'h13, mk("k_boost_ign", 0, 0, 0, 0, 0, 2));
        send_cmd(8'h20, mk("k_sleep_ign", 0, 0, 0, 0, 0, 2));
        send_cmd(8'hF0, mk("k_revive", 31, 31, 31, 31, 31, 0));
        check("k_revive_age", 32'(age), 32'(0));
        apply_reset();

        // Asynchronous reset in the middle of a tick period while asleep
        for (int k = 1; k <= 11; k++)
            tick_step(8'h08, mk($sformatf("r_dec%0d", k), 31, 31, 31, 31 - k, 31, 0));
        send_cmd(8'h20, mk("r_sleep", 31, 31, 31, 20, 31, 1));
        rnd = 8'h00;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("r_async.stats", 32'(stats_flat), 32'h1FF_FFFF);
        check("r_async.state", 32'(pet_state), 32'(0));
        check("r_async.sleep", 32'(is_sleeping), 32'(0));
        check("r_async.tick", 32'(tick), 32'(0));
        check("r_async.age", 32'(age), 32'(0));
        check("r_async.alarm", 32'(alarm), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("r_cnt_c%0d", c), 32'(tick), 32'(c == 3));
            if (c == 3) q.push_back(mk("r_first_tick", 31, 31, 31, 31, 31, 0));
            @(posedge clk);
            @(negedge clk);
        end

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(q.size()), 32'(0));
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pet_stats_engine.md
Name: pet_stats_engine

Overview:
- Parametrised successor to the fixed five-stat pet stats block.
- Holds N_STATS saturating stat channels of STAT_W bits. A built-in tick divider drives random decay of the channels.
- An awake/sleep/sick state machine gates that decay.
- Accepts care commands over a valid/ready byte interface fed by the UART receiver. Exposes flattened stats, per-channel alarms and sleep status to the UART reporter and top level.

Parameters:
N_STATS, 5, number of stat channels (1..8)
STAT_W, 5, width of each stat; max value is 2^STAT_W-1
TICK_DIV, 10_000_000, clocks per tick
BOOST, 4, increment applied by a feed/care command
ENERGY_IDX, 3, channel that recharges during sleep
ALARM_LVL, 8, alarm threshold (alarm when stat < ALARM_LVL)
SICK_COUNT, 2, number of zero-valued stats that forces SICK

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rnd  input  8  random byte from the LFSR, sampled on tick
cmd_valid  input  1  command byte present
cmd_data  input  8  [7:4] opcode, [3:0] channel index
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
tick  output  1  one-cycle pulse per tick
stats_flat  output  N_STATS*STAT_W  channel i at bits [i*STAT_W +: STAT_W]
alarm  output  N_STATS  registered, bit i = stat_i < ALARM_LVL
is_sleeping  output  1  high in SLEEP
pet_state  output  2  0 AWAKE, 1 SLEEP, 2 SICK
age  output  16  tick age counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous, active-high, on reset. Asserting reset at any time forces all reset values immediately.
- Reset values:
  - every stat = max; alarm = 0; tick = 0; tick counter = 0
  - pet_state = AWAKE; is_sleeping = 0; age = 0
  - cmd_ready = 1 after reset deasserts.
- Tick divider:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick = 1 in the cycle the counter equals TICK_DIV-1.
- cmd_ready = !tick. Commands and tick decay therefore never coincide. A command held valid during a tick cycle is accepted on the next cycle.
- Command effects take place on the accepting clock edge; new stats are visible the next cycle.
- Opcodes:
  - 0x1 BOOST: stat[idx] += BOOST, saturating at max. Ignored in SICK.
  - 0x2 SLEEP: AWAKE -> SLEEP. Ignored elsewhere.
  - 0x3 WAKE: SLEEP -> AWAKE. Ignored elsewhere.
  - 0xF REVIVE: SICK -> AWAKE with all stats reloaded to max. Ignored elsewhere.
  - All other opcodes, and idx >= N_STATS for BOOST, are accepted and dropped.
- Tick update, AWAKE: stat i decrements by 1 when rnd[i mod 8] = 1, saturating at 0.
- Tick update, SLEEP:
  - stat[ENERGY_IDX] increments by 1, saturating.
  - Every other stat decrements only when rnd[i mod 8] & rnd[(i+4) mod 8].
- Tick update, SICK: stats frozen.
- State transitions, evaluated on the values after the same-edge update, next state registered:
  - Count of stats == 0 >= SICK_COUNT -> SICK. This has priority over everything else.
  - In SLEEP, stat[ENERGY_IDX] == max -> AWAKE (auto-wake).
- alarm is registered from the current stats: one cycle lag after any stat change.
- Arithmetic: all arithmetic is done in STAT_W+1 bits and then clamped. No wrap-around is permitted.

Optional Feature:
- Macro: STATS_AGE_EN.
- Defined:
  - age increments by 1 on each tick while pet_state != SICK, saturating at 16'hFFFF.
  - REVIVE clears age to 0.
- Undefined: age is tied to 0 and no counter logic is built.

Test Plan:
- Reset/tick period: with TICK_DIV=4, release reset -> stats all 31, alarm 0, pet_state 0, tick pulses at cycles 3, 7, 11.
- Random decay: rnd=8'b00000101 held for 3 ticks -> stats 0 and 2 = 28, stats 1, 3 and 4 = 31. rnd=8'hFF until stat0 < 8 -> alarm[0]=1 one cycle after stat0 reaches 7.
- Boost saturation: cmd 0x12 with stat2=29 -> stat2=31. Cmd 0x17 (idx 7 >= N_STATS) -> accepted, no stat changes. Cmd_valid held across a tick cycle -> cmd_ready=0 that cycle, accepted on the next.
- Sleep and auto-wake: stat3=27, cmd 0x20 -> is_sleeping=1. rnd=8'h0F -> stat3 +1 per tick, others unchanged. After 4 ticks stat3=31 -> pet_state=0, is_sleeping=0.
- Sickness: rnd=8'hFF for 31 ticks -> all stats 0, pet_state=2. Further ticks and cmd 0x13 -> stats stay 0. Cmd 0xF0 -> all 31, pet_state=0 (age=0 if STATS_AGE_EN).
- Reset mid-operation: assert reset asynchronously mid-tick while SLEEP with stat3=20 -> immediately stats 31, pet_state 0, tick counter 0, age 0.
